regfile_wb_arbiter: RTL and testbench

- Sequences the register file's single write port and shares it between NREQ write-back requesters (ALU, load unit, multiply/divide).
- Grants one requester per cycle using round-robin and registers the winning address/data onto wr_en/wr_addr/wr_data.
- Keeps a 32-entry busy scoreboard of registers with an outstanding write. Issue logic uses it to block read-after-write and write-after-write hazards.

---
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back / issue bus of the register-file write-port arbiter.
// master: requesters + decode side; slave: the arbiter itself.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               issue_valid;
    logic [AW-1:0]      issue_addr;
    logic               issue_ready;
    logic [31:0]        busy;
    logic               flush;

    modport master (
        output req_valid, req_addr, req_data,
        output issue_valid, issue_addr, flush,
        input  req_ready, wr_en, wr_addr, wr_data,
        input  issue_ready, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        input  issue_valid, issue_addr, flush,
        output req_ready, wr_en, wr_addr, wr_data,
        output issue_ready, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port plus busy scoreboard.
// Ports: elk, nrst (async, active-high), bus (slave side of regfile_wb_arbiter_if).
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input logic                  elk,
    input logic                  nrst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [31:0]     busy_q, busy_d;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            issue_ok;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin : arb_comb
        int idx;
        idx   = 0;
        grant = '0;
        gidx  = '0;
        xfer  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!xfer && bus.req_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
                xfer       = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = bus.req_addr[i*AW +: AW];
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    // r0 is never reserved, so issues to it always pass.
    assign issue_ok = ~busy_q[bus.issue_addr] | (bus.issue_addr == '0);

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        if (xfer) begin
            rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            // A write-back to r0 consumes the grant but never reaches the file.
            if (sel_addr != '0) begin
                wr_en_d          = 1'b1;
                wr_addr_d        = sel_addr;
                wr_data_d        = sel_data;
                busy_d[sel_addr] = 1'b0;
            end
        end
        if (bus.flush) begin
            busy_d = '0;
        end else if (bus.issue_valid && issue_ok && bus.issue_addr != '0) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge elk or posedge nrst) begin
        if (nrst) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.req_ready   = nrst ? '0 : grant;
    assign bus.issue_ready = issue_ok;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus random traffic
// checked against a behavioural model of grant order, writes and scoreboard.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic elk  = 1'b0;
    logic nrst = 1'b1;
    always #5 elk = ~elk;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .elk  (elk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_rr      = 0;
    logic [31:0] m_busy    = '0;
    logic        m_wr_en   = 1'b0;
    logic [4:0]  m_wr_addr = '0;
    logic [31:0] m_wr_data = '0;
    logic [2:0]  exp_ready;
    logic        exp_iready;

    function automatic logic [2:0] mgrant(input logic [2:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (rr + k) % NREQ;
            if (v[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    function automatic int onehot_idx(input logic [2:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_busy = '0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
    endtask

    task automatic idle();
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.issue_valid = 0; bus.issue_addr = '0; bus.flush = 0;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic predict();
        exp_ready  = nrst ? 3'b000 : mgrant(bus.req_valid, m_rr);
        exp_iready = !m_busy[bus.issue_addr] || (bus.issue_addr == 5'd0);
    endtask

    // Advance one clock edge, updating the model from pre-edge inputs.
    task automatic tick();
        logic [31:0] n_busy;
        logic        n_en;
        logic [4:0]  n_addr;
        logic [31:0] n_data;
        int          n_rr;
        int          gi;
        logic [4:0]  a;
        predict();
        n_busy = m_busy; n_en = 0; n_addr = m_wr_addr; n_data = m_wr_data; n_rr = m_rr;
        gi = onehot_idx(exp_ready);
        if (gi >= 0) begin
            a = bus.req_addr[gi*AW +: AW];
            n_rr = (gi + 1) % NREQ;
            if (a != 0) begin
                n_en = 1; n_addr = a; n_data = bus.req_data[gi*DW +: DW];
                n_busy[a] = 1'b0;
            end
        end
        if (bus.flush) n_busy = '0;
        else if (bus.issue_valid && exp_iready && bus.issue_addr != 0)
            n_busy[bus.issue_addr] = 1'b1;
        @(posedge elk);
        #1;
        if (nrst) model_reset();
        else begin
            m_busy = n_busy; m_wr_en = n_en; m_wr_addr = n_addr;
            m_wr_data = n_data; m_rr = n_rr;
        end
    endtask

    task automatic test_reset();
        idle();
        nrst = 1'b1;
        bus.req_valid = 3'b111;
        #1;
        total++;
        if (bus.req_ready !== 3'b000) begin
            bad++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready);
        end
        tick();
        total++;
        if (bus.wr_en !== 1'b0) begin
            bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en);
        end
        total++;
        if (bus.busy !== 32'h0) begin
            bad++; $display("FAIL reset_busy got=%h exp=0", bus.busy);
        end
        model_reset();
        @(negedge elk);
        nrst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge elk);
        idle();
        set_req(1, 5'd9, 32'hDEADBEEF);
        #1;
        total++;
        if (bus.req_ready !== 3'b010) begin
            bad++; $display("FAIL single_ready got=%b exp=010", bus.req_ready);
        end
        tick();
        total++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9 || bus.wr_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_write got=%b/%0d/%h exp=1/9/deadbeef",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] e;
        // Steer rr_ptr back to 0 through a grant to requester 2.
        @(negedge elk);
        idle();
        set_req(2, 5'd1, 32'h1);
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge elk);
            idle();
            for (int i = 0; i < NREQ; i++) set_req(i, 5'(10 + i), 32'(32'hA000 + i));
            #1;
            e = 3'(1 << (k % 3));
            total++;
            if (bus.req_ready !== e) begin
                bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, e);
            end
            tick();
            total++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(10 + k % 3)) begin
                bad++;
                $display("FAIL rr_write%0d got=%b/%0d exp=1/%0d",
                         k, bus.wr_en, bus.wr_addr, 10 + k % 3);
            end
        end
    endtask

    task automatic test_r0_drop();
        logic [2:0] e;
        @(negedge elk);
        idle();
        set_req(1, 5'd0, 32'h1234);
        #1;
        total++;
        if (bus.req_ready !== 3'b010) begin
            bad++; $display("FAIL r0_ready got=%b exp=010", bus.req_ready);
        end
        tick();
        total++;
        if (bus.wr_en !== 1'b0) begin
            bad++; $display("FAIL r0_wr_en got=%b exp=0", bus.wr_en);
        end
        @(negedge elk);
        idle();
        #1;
        total++;
        if (bus.req_ready !== 3'b000) begin
            bad++; $display("FAIL r0_pulse got=%b exp=000", bus.req_ready);
        end
        tick();
        @(negedge elk);
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(20 + i), 32'h0);
        #1;
        e = 3'b100;
        total++;
        if (bus.req_ready !== e) begin
            bad++; $display("FAIL r0_rr_adv got=%b exp=%b", bus.req_ready, e);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        @(negedge elk);
        idle();
        bus.issue_valid = 1; bus.issue_addr = 5'd5;
        #1;
        total++;
        if (bus.issue_ready !== 1'b1) begin
            bad++; $display("FAIL sb_issue1 got=%b exp=1", bus.issue_ready);
        end
        tick();
        total++;
        if (bus.busy[5] !== 1'b1) begin
            bad++; $display("FAIL sb_set got=%b exp=1", bus.busy[5]);
        end
        @(negedge elk);
        #1;
        total++;
        if (bus.issue_ready !== 1'b0) begin
            bad++; $display("FAIL sb_block got=%b exp=0", bus.issue_ready);
        end
        tick();
        @(negedge elk);
        set_req(0, 5'd5, 32'h55);
        #1;
        total++;
        if (bus.issue_ready !== 1'b0 || bus.req_ready !== 3'b001) begin
            bad++;
            $display("FAIL sb_wb_pre got=%b/%b exp=0/001", bus.issue_ready, bus.req_ready);
        end
        tick();
        total++;
        if (bus.busy[5] !== 1'b0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5) begin
            bad++;
            $display("FAIL sb_clear got=%b/%b/%0d exp=0/1/5", bus.busy[5], bus.wr_en, bus.wr_addr);
        end
        @(negedge elk);
        idle();
        bus.issue_valid = 1; bus.issue_addr = 5'd5;
        #1;
        total++;
        if (bus.issue_ready !== 1'b1) begin
            bad++; $display("FAIL sb_retry got=%b exp=1", bus.issue_ready);
        end
        tick();
        total++;
        if (bus.busy !== 32'h20) begin
            bad++; $display("FAIL sb_reset_busy got=%h exp=00000020", bus.busy);
        end
    endtask

    task automatic test_flush();
        @(negedge elk);
        idle(); bus.issue_valid = 1; bus.issue_addr = 5'd3;
        tick();
        @(negedge elk);
        bus.issue_addr = 5'd7;
        tick();
        total++;
        if (bus.busy !== 32'h000000A8) begin
            bad++; $display("FAIL fl_pre got=%h exp=000000a8", bus.busy);
        end
        @(negedge elk);
        idle();
        bus.flush = 1; bus.issue_valid = 1; bus.issue_addr = 5'd8;
        set_req(2, 5'd9, 32'hF00D);
        tick();
        total++;
        if (bus.busy !== 32'h0) begin
            bad++; $display("FAIL fl_busy got=%h exp=0", bus.busy);
        end
        total++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9 || bus.wr_data !== 32'hF00D) begin
            bad++;
            $display("FAIL fl_write got=%b/%0d/%h exp=1/9/f00d", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        @(negedge elk);
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge elk);
        idle(); bus.issue_valid = 1; bus.issue_addr = 5'd6;
        tick();
        @(negedge elk);
        idle();
        set_req(2, 5'd4, 32'h44);
        #1;
        total++;
        if (bus.req_ready !== 3'b100) begin
            bad++; $display("FAIL rm_grant got=%b exp=100", bus.req_ready);
        end
        tick();
        #2;
        nrst = 1'b1;
        #1;
        model_reset();
        total++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 32'h0 || bus.req_ready !== 3'b000) begin
            bad++;
            $display("FAIL rm_async got=%b/%h/%b exp=0/0/000", bus.wr_en, bus.busy, bus.req_ready);
        end
        @(negedge elk);
        nrst = 1'b0;
        idle();
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(1 + i), 32'h0);
        #1;
        total++;
        if (bus.req_ready !== 3'b001) begin
            bad++; $display("FAIL rm_rr0 got=%b exp=001", bus.req_ready);
        end
        tick();
        @(negedge elk);
        idle();
        tick();
    endtask

    task automatic test_random();
        logic        pv [NREQ];
        logic [4:0]  pa [NREQ];
        logic [31:0] pd [NREQ];
        int          gi;
        for (int i = 0; i < NREQ; i++) pv[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge elk);
            idle();
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(1, 0) == 1) begin
                    pv[i] = 1; pa[i] = 5'($urandom_range(31, 0)); pd[i] = $urandom;
                end
                if (pv[i]) set_req(i, pa[i], pd[i]);
            end
            bus.flush       = ($urandom_range(19, 0) == 0);
            bus.issue_valid = $urandom_range(1, 0) == 1;
            bus.issue_addr  = 5'($urandom_range(31, 0));
            predict();
            gi = onehot_idx(exp_ready);
            // Same-register issue and write-back on one edge is left unexercised.
            if (gi >= 0 && pa[gi] == bus.issue_addr) bus.issue_valid = 0;
            predict();
            #1;
            total++;
            if (bus.req_ready !== exp_ready || bus.issue_ready !== exp_iready) begin
                bad++;
                $display("FAIL rnd_comb c=%0d got=%b/%b exp=%b/%b",
                         c, bus.req_ready, bus.issue_ready, exp_ready, exp_iready);
            end
            tick();
            if (gi >= 0) pv[gi] = 0;
            total++;
            if (bus.wr_en !== m_wr_en || bus.busy !== m_busy ||
                (m_wr_en && (bus.wr_addr !== m_wr_addr || bus.wr_data !== m_wr_data))) begin
                bad++;
                $display("FAIL rnd_state c=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h",
                         c, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy,
                         m_wr_en, m_wr_addr, m_wr_data, m_busy);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_round_robin();
        test_r0_drop();
        test_scoreboard();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
